// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_pkg;
  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

  typedef logic [ILEN-1:0] instr_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head is read combinationally and reads as zero when empty.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flush beats push so a response landing in the redirect cycle is dropped.
  assign w_do_push = push_i && !flush_i;
  assign w_do_pop  = pop_i && (r_count != '0) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
  end

  assign rdata_o = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign count_o = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC sequencing, credit-limited requests to a 1-cycle memory,
// and a small buffer presenting {pc, instr} to decode with redirect/flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [ILEN-1:0]  imem_rdata_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  fetch_pc_o,
  output logic [ILEN-1:0]  fetch_instr_o,
  input  logic             fetch_ready_i
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    instr_t          instr;
  } fetch_entry_t;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_used;
  logic            w_pop;
  logic            w_issue;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;

  assign fetch_valid_o = (w_count != '0) && !redirect_i;
  assign w_pop         = fetch_valid_o && fetch_ready_i;

  // Slots committed = buffered + in flight, minus the entry leaving this cycle.
  assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue = !rst_i && !redirect_i && (w_used < (CW+1)'(FIFO_DEPTH));

  assign imem_req_o  = w_issue;
  assign imem_addr_o = r_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_req_pc <= r_pc;
      if (redirect_i)
        r_pc <= redirect_pc_i & ~XLEN'(3);
      else if (w_issue)
        r_pc <= r_pc + XLEN'(PC_STEP);
    end
  end

  assign w_wdata = '{pc: r_req_pc, instr: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (r_inflight),
    .wdata_i (w_wdata),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  assign fetch_pc_o    = w_head.pc;
  assign fetch_instr_o = w_head.instr;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetches are queued as requests go out and
// matched against transfers to decode; directed scenarios plus a randomized phase.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_instr_o;
  logic        fetch_ready_i;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_pc_o    (fetch_pc_o),
    .fetch_instr_o (fetch_instr_o),
    .fetch_ready_i (fetch_ready_i)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t exp_q[$];

  // Reference memory contents: any address-derived word works.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory model: answers the previous cycle's request one cycle later.
  logic        req_seen = 1'b0;
  logic [31:0] addr_seen = '0;
  initial begin
    imem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk_i);
      #1;
      imem_rdata_i = req_seen ? mem_f(addr_seen) : 32'hDEAD_BEEF;
    end
  end

  // Monitor / scoreboard: samples every cycle at negedge+2, after stimulus has settled.
  logic [31:0] exp_req_addr = RESET_PC;
  int          nreq = 0, npop = 0, written = 0;
  logic [1:0]  hist = 2'b00;
  logic        started = 1'b0;

  task automatic flush_model(input logic [31:0] tgt);
    nreq = 0; npop = 0; written = 0; hist = 2'b00;
    exp_q.delete();
    exp_req_addr = tgt;
  endtask

  initial begin
    exp_t e;
    logic pop;
    int   outstanding;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        chk("req_during_reset", {31'b0, imem_req_o}, 32'd0);
        req_seen = 1'b0;
        started  = 1'b1;
        flush_model(RESET_PC);
      end else if (started) begin
        written     = written + int'(hist[1]);
        pop         = fetch_valid_o && fetch_ready_i;
        outstanding = nreq - npop;
        chk("valid", {31'b0, fetch_valid_o}, {31'b0, (!redirect_i && (written - npop) > 0)});
        chk("req_credit", {31'b0, imem_req_o},
            {31'b0, (!redirect_i && (outstanding - int'(pop)) < DEPTH)});
        if (pop) begin
          if (exp_q.size() == 0) begin
            chk("xfer_unexpected", fetch_pc_o, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_pc", fetch_pc_o, e.pc);
            chk("xfer_instr", fetch_instr_o, e.instr);
            $display("xfer pc=%h instr=%h", fetch_pc_o, fetch_instr_o);
          end
          npop++;
        end
        if (imem_req_o) begin
          chk("req_addr", imem_addr_o, exp_req_addr);
          exp_q.push_back('{pc: exp_req_addr, instr: mem_f(exp_req_addr)});
          exp_req_addr = exp_req_addr + 32'd4;
          nreq++;
        end
        req_seen  = imem_req_o;
        addr_seen = imem_addr_o;
        hist      = {hist[0], imem_req_o};
        if (redirect_i) flush_model(redirect_pc_i & ~32'd3);
      end
    end
  end

  // Drive one cycle of inputs at negedge; outputs may be inspected on return (negedge+3).
  task automatic cyc(input logic rdy, input logic redir, input logic [31:0] tgt, input logic rst);
    @(negedge clk_i);
    fetch_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = tgt;
    rst_i         = rst;
    #3;
  endtask

  initial begin
    int reqs, first_valid, gaps;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; fetch_ready_i = 1'b0;

    // Reset, then hold decode stalled.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    chk("rst_addr", imem_addr_o, RESET_PC);
    chk("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("rst_pc", fetch_pc_o, 32'd0);
    chk("rst_instr", fetch_instr_o, 32'd0);
    chk("first_req", {31'b0, imem_req_o}, 32'd1);
    reqs = 1; first_valid = -1;
    for (int i = 1; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      reqs += int'(imem_req_o);
      if (fetch_valid_o && first_valid < 0) first_valid = i;
    end
    chk("stall_reqs", reqs, DEPTH);
    chk("first_valid_latency", first_valid, 2);
    chk("stall_head_pc", fetch_pc_o, 32'h0);

    // Release decode: no bubbles.
    gaps = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0);
      gaps += int'(!fetch_valid_o);
    end
    chk("no_gap", gaps, 0);

    // Fill, then redirect to 0x100.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h100, 0);
    chk("redir_no_valid", {31'b0, fetch_valid_o}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("redir_addr", imem_addr_o, 32'h100);
    cyc(1, 0, 0, 0);
    chk("redir_r2_valid", {31'b0, fetch_valid_o}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("redir_r3_valid", {31'b0, fetch_valid_o}, 32'd1);
    chk("redir_r3_pc", fetch_pc_o, 32'h100);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

    // Address wrap.
    cyc(1, 1, 32'hFFFF_FFFC, 0);
    cyc(1, 0, 0, 0);
    chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_addr1", imem_addr_o, 32'h0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

    // Unaligned target while a transfer would otherwise happen.
    cyc(1, 1, 32'h203, 0);
    chk("redir203_no_valid", {31'b0, fetch_valid_o}, 32'd0);
    cyc(1, 0, 0, 0);
    chk("redir203_addr", imem_addr_o, 32'h200);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);

    // Reset mid-stream with a response pending.
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("midrst_addr", imem_addr_o, RESET_PC);
    chk("midrst_valid", {31'b0, fetch_valid_o}, 32'd0);
    chk("midrst_req", {31'b0, imem_req_o}, 32'd1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      logic        r_rst, r_red, r_rdy;
      logic [31:0] tgt;
      r_rst = ($urandom_range(0, 99) == 0);
      r_red = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cyc(r_rdy, r_red, tgt, r_rst);
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
